// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded operands and control each cycle,
// holds on a memory-stall freeze, loads an all-zero bubble on flush or an empty ID slot.
module id_ex_stage_reg #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [DW-1:0]    pc_in,
  input  logic [DW-1:0]    val_rn_in,
  input  logic [DW-1:0]    val_rm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic             imm_in,
  input  logic [23:0]      signed_imm24_in,
  input  logic [3:0]       dest_in,
  input  logic [3:0]       src1_in,
  input  logic [3:0]       src2_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             wb_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       status_in,
  output logic             valid_out,
  output logic [DW-1:0]    pc_out,
  output logic [DW-1:0]    val_rn_out,
  output logic [DW-1:0]    val_rm_out,
  output logic [11:0]      shift_operand_out,
  output logic             imm_out,
  output logic [23:0]      signed_imm24_out,
  output logic [3:0]       dest_out,
  output logic [3:0]       src1_out,
  output logic [3:0]       src2_out,
  output logic [3:0]       exe_cmd_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic             wb_en_out,
  output logic             b_out,
  output logic             s_out,
  output logic [3:0]       status_out,
  output logic             val2_mem_sel,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Handshake: valid_in qualifies the ID bundle for one edge; there is no ready,
  // freeze is the only back-pressure and flush the only kill, flush taking priority.
  logic             r_valid;
  logic [DW-1:0]    r_pc;
  logic [DW-1:0]    r_val_rn;
  logic [DW-1:0]    r_val_rm;
  logic [11:0]      r_shift_operand;
  logic             r_imm;
  logic [23:0]      r_signed_imm24;
  logic [3:0]       r_dest;
  logic [3:0]       r_src1;
  logic [3:0]       r_src2;
  logic [3:0]       r_exe_cmd;
  logic             r_mem_r_en;
  logic             r_mem_w_en;
  logic             r_wb_en;
  logic             r_b;
  logic             r_s;
  logic [3:0]       r_status;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic w_capture;
  logic w_bubble;

  assign w_capture = ~flush & ~freeze & valid_in;
  assign w_bubble  = flush | (~freeze & ~valid_in);

  // Bubbles clear data fields too, so downstream never sees stale operands.
  always_ff @(posedge clk) begin
    if (!rst || (w_bubble && !w_capture)) begin
      r_valid         <= 1'b0;
      r_pc            <= '0;
      r_val_rn        <= '0;
      r_val_rm        <= '0;
      r_shift_operand <= '0;
      r_imm           <= 1'b0;
      r_signed_imm24  <= '0;
      r_dest          <= '0;
      r_src1          <= '0;
      r_src2          <= '0;
      r_exe_cmd       <= '0;
      r_mem_r_en      <= 1'b0;
      r_mem_w_en      <= 1'b0;
      r_wb_en         <= 1'b0;
      r_b             <= 1'b0;
      r_s             <= 1'b0;
      r_status        <= '0;
    end else if (w_capture) begin
      r_valid         <= 1'b1;
      r_pc            <= pc_in;
      r_val_rn        <= val_rn_in;
      r_val_rm        <= val_rm_in;
      r_shift_operand <= shift_operand_in;
      r_imm           <= imm_in;
      r_signed_imm24  <= signed_imm24_in;
      r_dest          <= dest_in;
      r_src1          <= src1_in;
      r_src2          <= src2_in;
      r_exe_cmd       <= exe_cmd_in;
      r_mem_r_en      <= mem_r_en_in;
      r_mem_w_en      <= mem_w_en_in;
      r_wb_en         <= wb_en_in;
      r_b             <= b_in;
      r_s             <= s_in;
      r_status        <= status_in;
    end
  end

  // Saturating so a long stall-heavy run never reports a misleadingly small count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign valid_out         = r_valid;
  assign pc_out            = r_pc;
  assign val_rn_out        = r_val_rn;
  assign val_rm_out        = r_val_rm;
  assign shift_operand_out = r_shift_operand;
  assign imm_out           = r_imm;
  assign signed_imm24_out  = r_signed_imm24;
  assign dest_out          = r_dest;
  assign src1_out          = r_src1;
  assign src2_out          = r_src2;
  assign exe_cmd_out       = r_exe_cmd;
  assign mem_r_en_out      = r_mem_r_en;
  assign mem_w_en_out      = r_mem_w_en;
  assign wb_en_out         = r_wb_en;
  assign b_out             = r_b;
  assign s_out             = r_s;
  assign status_out        = r_status;
  assign val2_mem_sel      = r_mem_r_en | r_mem_w_en;
  assign bubble_cnt        = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: driver pushes expected register contents per edge,
// a monitor pops and compares after each edge and checks the bubble invariant.
module tb_id_ex_stage_reg;

  localparam int CNT_W = 4;
  localparam int EW    = 159 + 1 + CNT_W;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic        imm;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic [3:0]  status;
  } fld_t;

  logic clk;
  logic rst;
  logic freeze;
  logic flush;
  fld_t d;
  wire fld_t q;
  wire val2_mem_sel;
  wire [CNT_W-1:0] bubble_cnt;

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int total;
  int bad;

  fld_t m;
  logic [CNT_W-1:0] m_cnt;

  id_ex_stage_reg #(.DW(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .valid_in(d.valid), .pc_in(d.pc), .val_rn_in(d.val_rn), .val_rm_in(d.val_rm),
    .shift_operand_in(d.shift_operand), .imm_in(d.imm), .signed_imm24_in(d.signed_imm24),
    .dest_in(d.dest), .src1_in(d.src1), .src2_in(d.src2), .exe_cmd_in(d.exe_cmd),
    .mem_r_en_in(d.mem_r_en), .mem_w_en_in(d.mem_w_en), .wb_en_in(d.wb_en),
    .b_in(d.b), .s_in(d.s), .status_in(d.status),
    .valid_out(q.valid), .pc_out(q.pc), .val_rn_out(q.val_rn), .val_rm_out(q.val_rm),
    .shift_operand_out(q.shift_operand), .imm_out(q.imm), .signed_imm24_out(q.signed_imm24),
    .dest_out(q.dest), .src1_out(q.src1), .src2_out(q.src2), .exe_cmd_out(q.exe_cmd),
    .mem_r_en_out(q.mem_r_en), .mem_w_en_out(q.mem_w_en), .wb_en_out(q.wb_en),
    .b_out(q.b), .s_out(q.s), .status_out(q.status),
    .val2_mem_sel(val2_mem_sel), .bubble_cnt(bubble_cnt)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b0;
    freeze = 1'b0;
    flush = 1'b0;
    d = '0;
  end

  // Driver: apply one edge of stimulus and push what the register must hold after it.
  task automatic step(input string tag, input logic r, input logic fr, input logic fl,
                      input fld_t in);
    @(negedge clk);
    rst = r;
    freeze = fr;
    flush = fl;
    d = in;
    case (1'b1)
      !r: begin
        m = '0;
        m_cnt = '0;
      end
      fl: begin
        m = '0;
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
      fr: ;
      default: begin
        if (in.valid) m = in;
        else begin
          m = '0;
          if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end
      end
    endcase
    exp_q.push_back({m, m.mem_r_en | m.mem_w_en, m_cnt});
    tag_q.push_back(tag);
  endtask

  function automatic fld_t rand_fld();
    fld_t f;
    f.valid         = 1'($urandom_range(0, 3) != 0);
    f.pc            = $urandom;
    f.val_rn        = $urandom;
    f.val_rm        = $urandom;
    f.shift_operand = 12'($urandom_range(0, 4095));
    f.imm           = 1'($urandom_range(0, 1));
    f.signed_imm24  = 24'($urandom);
    f.dest          = 4'($urandom_range(0, 15));
    f.src1          = 4'($urandom_range(0, 15));
    f.src2          = 4'($urandom_range(0, 15));
    f.exe_cmd       = 4'($urandom_range(0, 15));
    f.mem_r_en      = 1'($urandom_range(0, 1));
    f.mem_w_en      = 1'($urandom_range(0, 1));
    f.wb_en         = 1'($urandom_range(0, 1));
    f.b             = 1'($urandom_range(0, 1));
    f.s             = 1'($urandom_range(0, 1));
    f.status        = 4'($urandom_range(0, 15));
    return f;
  endfunction

  // Scoreboard monitor
  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;
  string         mon_tag;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {q, val2_mem_sel, bubble_cnt};
      total++;
      if (mon_act !== mon_exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", mon_tag, mon_act, mon_exp);
      end
      total++;
      if (q.valid !== 1'b1 && ({q.wb_en, q.mem_r_en, q.mem_w_en, q.b, q.s} !== 5'b0)) begin
        bad++;
        $display("FAIL invariant_%s: got ctl=%b expected 00000 with valid_out=%b",
                 mon_tag, {q.wb_en, q.mem_r_en, q.mem_w_en, q.b, q.s}, q.valid);
      end
    end
  end

  // Directed vectors then random traffic
  initial begin
    fld_t v;
    m = '0;
    m_cnt = '0;
    total = 0;
    bad = 0;

    step("reset0", 1'b0, 1'b1, 1'b1, '1);
    step("reset1", 1'b0, 1'b0, 1'b0, '1);

    v = '0; v.valid = 1'b1; v.pc = 32'h0000_0104;
    step("first_load", 1'b1, 1'b0, 1'b0, v);

    v = '0; v.valid = 1'b1; v.pc = 32'h0000_0108; v.shift_operand = 12'h1A3; v.imm = 1'b1;
    v.val_rm = 32'hDEAD_BEEF; v.mem_r_en = 1'b1; v.exe_cmd = 4'h2; v.status = 4'hA;
    step("normal_load", 1'b1, 1'b0, 1'b0, v);

    v.mem_w_en = 1'b1; v.dest = 4'h3;
    step("both_mem", 1'b1, 1'b0, 1'b0, v);

    v = '0; v.valid = 1'b1; v.wb_en = 1'b1; v.dest = 4'h5; v.val_rn = 32'h1234_5678;
    step("load_dest5", 1'b1, 1'b0, 1'b0, v);
    v.dest = 4'hA; v.val_rn = 32'h8765_4321;
    for (int i = 0; i < 3; i++) step("freeze_hold", 1'b1, 1'b1, 1'b0, v);
    step("freeze_release", 1'b1, 1'b0, 1'b0, v);

    v.valid = 1'b0;
    step("freeze_invalid", 1'b1, 1'b1, 1'b0, v);
    v.valid = 1'b1; v.pc = 32'h0000_0200;
    step("flush_freeze", 1'b1, 1'b1, 1'b1, v);
    step("flush_only", 1'b1, 1'b0, 1'b1, v);
    step("reload", 1'b1, 1'b0, 1'b0, v);
    step("reset_mid_freeze", 1'b0, 1'b1, 1'b0, v);
    step("reload2", 1'b1, 1'b0, 1'b0, v);
    step("reset_mid_flush", 1'b0, 1'b0, 1'b1, v);

    for (int i = 0; i < 20; i++) begin
      v = rand_fld();
      v.valid = 1'b0;
      step("bubble_count", 1'b1, 1'b0, 1'b0, v);
    end
    step("cnt_sat_freeze", 1'b1, 1'b1, 1'b0, rand_fld());
    step("cnt_reset", 1'b0, 1'b0, 1'b0, rand_fld());

    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 7) == 0), rand_fld());
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
